// File: rtl/fpga_fabric.sv
// -----------------------------------------------------------------------------
// fpga_fabric -- minimal serially configured FPGA fabric (Oktane fabric top).
//
// A single long shift register holds the whole configuration. It is loaded
// one bit per s_clk rise while flag=1. While flag=0 the fabric runs:
// 8 LUT4 logic blocks, each with an optional flop, and 24 bidirectional pads.
// Every LB input and every pad output picks its source from a shared 32-entry
// source bus: the 24 pad inputs followed by the 8 LB outputs.
//
// Ports
//   s_clk  in     1   sole clock, all flops rise-edge
//   rst_n  in     1   asynchronous, active-low reset
//   sin    in     1   serial config data in
//   flag   in     1   1 = configure (shift chain), 0 = run fabric
//   f_clk  in     1   fabric step strobe, sampled on s_clk (not used as a clock)
//   sout   out    1   serial config data out (tail of the chain)
//   p      inout  24  user pads
//
// Stream layout (stream bit k is the k-th bit shifted in and ends up at
// cfg_reg[CFG_BITS-1-k]; multi-bit fields are MSB first):
//   LB j, base 37*j : sel0[4:0], sel1, sel2, sel3, lut[15:0], ff_en
//   pad i, base 296+6*i : oe, sel[4:0]
//   stream bits 440 and up are reserved and only shift through.
// -----------------------------------------------------------------------------
module fpga_fabric #(
    parameter int CFG_BITS = 1401,
    parameter int N_LB     = 8,
    parameter int N_PAD    = 24
) (
    input  logic             s_clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             flag,
    input  logic             f_clk,
    output logic             sout,
    inout  wire [N_PAD-1:0]  p
);

    localparam int USED_BITS  = 440;
    localparam int LB_STRIDE  = 37;
    localparam int PAD_BASE   = 296;
    localparam int PAD_STRIDE = 6;
    localparam int N_SRC      = N_PAD + N_LB;

    logic [CFG_BITS-1:0]  cfg_reg;
    logic                 f_q_reg;
    logic [N_LB-1:0]      ff_reg;

    // Configuration viewed in stream order: stream[k] = k-th bit shifted in.
    logic [USED_BITS-1:0] stream;

    logic [3:0][4:0]      lb_sel [N_LB];
    logic [15:0]          lb_lut [N_LB];
    logic [N_LB-1:0]      lb_ff_en;
    logic [N_LB-1:0]      lb_comb;
    logic [N_LB-1:0]      lb_out;

    logic [N_PAD-1:0]     pad_oe;
    logic [4:0]           pad_sel [N_PAD];

    logic [N_SRC-1:0]     src_vec;
    logic                 tick;

    // -------------------------------------------------------------------------
    // Config chain, edge detector and LB flops
    // -------------------------------------------------------------------------
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_reg <= '0;
            f_q_reg <= 1'b0;
            ff_reg  <= '0;
        end else begin
            f_q_reg <= f_clk;
            if (flag) begin
                cfg_reg <= {cfg_reg[CFG_BITS-2:0], sin};
            end
            if (tick) begin
                ff_reg <= lb_comb;
            end
        end
    end

    assign sout = cfg_reg[CFG_BITS-1];

    // A fabric step happens on the first s_clk after f_clk rises, and never
    // while configuring, so a long f_clk high produces exactly one step.
    assign tick = f_clk & ~f_q_reg & ~flag;

    // While configuring, the chain sweeps arbitrary patterns through every
    // field; forcing the source bus low keeps a half-loaded chain from forming
    // an oscillating loop. Nothing on the source bus is observable then anyway:
    // pads are released and the flops hold.
    assign src_vec = flag ? '0 : {lb_out, p};

    // -------------------------------------------------------------------------
    // Field decode
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < USED_BITS; gi++) begin : g_stream
            assign stream[gi] = cfg_reg[CFG_BITS-1-gi];
        end

        for (genvar gi = 0; gi < N_LB; gi++) begin : g_lb
            localparam int B = LB_STRIDE * gi;

            for (genvar gj = 0; gj < 4; gj++) begin : g_sel
                localparam int O = B + 5 * gj;
                assign lb_sel[gi][gj] = {stream[O], stream[O+1], stream[O+2],
                                         stream[O+3], stream[O+4]};
            end

            for (genvar gm = 0; gm < 16; gm++) begin : g_lut
                assign lb_lut[gi][15-gm] = stream[B+20+gm];
            end

            assign lb_ff_en[gi] = stream[B+36];

            // LUT address is {in3, in2, in1, in0}.
            assign lb_comb[gi] = lb_lut[gi][{src_vec[lb_sel[gi][3]],
                                             src_vec[lb_sel[gi][2]],
                                             src_vec[lb_sel[gi][1]],
                                             src_vec[lb_sel[gi][0]]}];

            assign lb_out[gi] = lb_ff_en[gi] ? ff_reg[gi] : lb_comb[gi];
        end

        for (genvar gi = 0; gi < N_PAD; gi++) begin : g_pad
            localparam int B = PAD_BASE + PAD_STRIDE * gi;

            assign pad_oe[gi]  = stream[B];
            assign pad_sel[gi] = {stream[B+1], stream[B+2], stream[B+3],
                                  stream[B+4], stream[B+5]};

            assign p[gi] = (pad_oe[gi] & ~flag) ? src_vec[pad_sel[gi]] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_fpga_fabric.sv
// -----------------------------------------------------------------------------
// tb_fpga_fabric -- self-checking bench for fpga_fabric.
//
// Every pad carries a pullup, so a released (Hi-Z) pad reads as 1. Tests that
// look for Hi-Z arrange for the fabric's would-be output to be 0, which makes
// a released pad distinguishable from a driven one.
// Inputs change on the falling edge of s_clk; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_fpga_fabric;

    localparam int CFG_BITS = 1401;
    localparam int N_PAD    = 24;

    logic              s_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sin   = 1'b0;
    logic              flag  = 1'b0;
    logic              f_clk = 1'b0;
    logic              sout;
    wire  [N_PAD-1:0]  p;

    logic [N_PAD-1:0]  drv_en  = '0;
    logic [N_PAD-1:0]  drv_val = '0;

    int n_cmp = 0;
    int n_err = 0;

    logic [439:0]         cfg_s;
    logic [CFG_BITS-1:0]  rnd;

    always #5 s_clk = ~s_clk;

    generate
        for (genvar gi = 0; gi < N_PAD; gi++) begin : g_tb_pad
            pullup (p[gi]);
            assign p[gi] = drv_en[gi] ? drv_val[gi] : 1'bz;
        end
    endgenerate

    fpga_fabric #(
        .CFG_BITS (CFG_BITS),
        .N_LB     (8),
        .N_PAD    (N_PAD)
    ) dut (
        .s_clk (s_clk),
        .rst_n (rst_n),
        .sin   (sin),
        .flag  (flag),
        .f_clk (f_clk),
        .sout  (sout),
        .p     (p)
    );

    // ---------------------------------------------------------------- checking
    task automatic chk(input string nm, input logic [23:0] act,
                       input logic [23:0] exp, input bit quiet);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end else if (!quiet) begin
            $display("ok   %s: value %h", nm, act);
        end
    endtask

    // ------------------------------------------------------- config building
    task automatic put(input int off, input int w, input logic [15:0] v);
        for (int m = 0; m < w; m++) cfg_s[off+m] = v[w-1-m];
    endtask

    task automatic lb_cfg(input int j, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [4:0] s3,
                          input logic [15:0] lut, input logic fe);
        int b;
        b = 37 * j;
        put(b,      5, {11'd0, s0});
        put(b + 5,  5, {11'd0, s1});
        put(b + 10, 5, {11'd0, s2});
        put(b + 15, 5, {11'd0, s3});
        put(b + 20, 16, lut);
        put(b + 36, 1, {15'd0, fe});
    endtask

    task automatic pad_cfg(input int i, input logic oe, input logic [4:0] sel);
        int b;
        b = 296 + 6 * i;
        put(b,     1, {15'd0, oe});
        put(b + 1, 5, {11'd0, sel});
    endtask

    // 0 = all zero, 1 = passthrough, 2 = AND gate, 3 = toggle
    task automatic build(input int id);
        cfg_s = '0;
        case (id)
            1: pad_cfg(1, 1'b1, 5'd0);
            2: begin
                lb_cfg(0, 5'd0, 5'd1, 5'd0, 5'd0, 16'h8888, 1'b0);
                pad_cfg(2, 1'b1, 5'd24);
            end
            3: begin
                lb_cfg(0, 5'd24, 5'd0, 5'd0, 5'd0, 16'h5555, 1'b1);
                pad_cfg(2, 1'b1, 5'd24);
            end
            default: ;
        endcase
    endtask

    // Shifts cfg_s (stream bit 0 first) followed by zeros for the reserved tail.
    task automatic load_cfg();
        @(negedge s_clk);
        flag = 1'b1;
        for (int k = 0; k < CFG_BITS; k++) begin
            sin = (k < 440) ? cfg_s[k] : 1'b0;
            @(negedge s_clk);
        end
        flag = 1'b0;
        sin  = 1'b0;
    endtask

    task automatic pulse();
        @(negedge s_clk);
        f_clk = 1'b1;
        @(negedge s_clk);
        f_clk = 1'b0;
        #1;
    endtask

    task automatic async_reset();
        @(negedge s_clk);
        #1 rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge s_clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------ vector table
    typedef struct {
        int          cfg_id;
        logic        flg;
        logic [23:0] den;
        logic [23:0] dval;
        logic [23:0] exp_p;
        string       name;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int cur_id;
        int ok_cnt;

        vecs[0]  = '{0, 1'b0, 24'h0, 24'h0, 24'hFFFFFF, "zero_all_z"};
        vecs[1]  = '{0, 1'b0, 24'h3, 24'h0, 24'hFFFFFC, "zero_drv00"};
        vecs[2]  = '{1, 1'b0, 24'h1, 24'h0, 24'hFFFFFC, "pass_p0_0"};
        vecs[3]  = '{1, 1'b0, 24'h1, 24'h1, 24'hFFFFFF, "pass_p0_1"};
        vecs[4]  = '{1, 1'b1, 24'h1, 24'h0, 24'hFFFFFE, "pass_cfg_z"};
        vecs[5]  = '{2, 1'b0, 24'h3, 24'h0, 24'hFFFFF8, "and_00"};
        vecs[6]  = '{2, 1'b0, 24'h3, 24'h1, 24'hFFFFF9, "and_01"};
        vecs[7]  = '{2, 1'b0, 24'h3, 24'h2, 24'hFFFFFA, "and_10"};
        vecs[8]  = '{2, 1'b0, 24'h3, 24'h3, 24'hFFFFFF, "and_11"};
        vecs[9]  = '{2, 1'b1, 24'h3, 24'h0, 24'hFFFFFC, "and_cfg_z"};
        vecs[10] = '{2, 1'b0, 24'h3, 24'h0, 24'hFFFFF8, "and_held"};

        // ---- reset state
        repeat (3) @(negedge s_clk);
        #1;
        chk("rst_sout", {23'd0, sout}, 24'h0, 1'b0);
        chk("rst_pads", p, 24'hFFFFFF, 1'b0);
        release_reset();

        // ---- chain replay: 1401 random bits, then 1401 ones
        for (int k = 0; k < CFG_BITS; k++) rnd[k] = 1'($urandom_range(0, 1));
        ok_cnt = n_err;
        @(negedge s_clk);
        flag = 1'b1;
        for (int n = 0; n < 2 * CFG_BITS - 1; n++) begin
            sin = (n < CFG_BITS) ? rnd[n] : 1'b1;
            @(negedge s_clk);
            #1;
            if (n + 1 < CFG_BITS)
                chk("chain_pre", {23'd0, sout}, 24'h0, 1'b1);
            else
                chk("chain_replay", {23'd0, sout}, {23'd0, rnd[n + 1 - CFG_BITS]}, 1'b1);
        end
        $display("ok   chain: %0d replay errors", n_err - ok_cnt);
        sin = 1'b1;
        @(negedge s_clk);
        #1;
        chk("chain_ones", {23'd0, sout}, 24'h1, 1'b0);

        // ---- reset mid-shift: sout clears at once, partial load discarded
        async_reset();
        chk("rst_shift_sout", {23'd0, sout}, 24'h0, 1'b0);
        release_reset();
        flag = 1'b1;
        sin  = 1'b1;
        repeat (CFG_BITS - 1) @(negedge s_clk);
        #1;
        chk("rst_shift_discard", {23'd0, sout}, 24'h0, 1'b0);
        flag = 1'b0;
        sin  = 1'b0;
        async_reset();
        release_reset();

        // ---- table-driven combinational vectors
        cur_id = -1;
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].cfg_id != cur_id) begin
                drv_en = '0;
                build(vecs[i].cfg_id);
                load_cfg();
                cur_id = vecs[i].cfg_id;
            end
            @(negedge s_clk);
            drv_en  = vecs[i].den;
            drv_val = vecs[i].dval;
            flag    = vecs[i].flg;
            #1;
            chk(vecs[i].name, p, vecs[i].exp_p, 1'b0);
            #1 flag = 1'b0;
        end
        drv_en = '0;

        // ---- zero config: a tick leaves everything released
        build(0);
        load_cfg();
        pulse();
        chk("zero_tick", p, 24'hFFFFFF, 1'b0);

        // ---- toggle: 8 pulses flip p[2], then f_clk held high steps once
        build(3);
        load_cfg();
        #1;
        chk("tog_init", p, 24'hFFFFFB, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            pulse();
            chk($sformatf("tog_pulse%0d", n), p,
                (n % 2 == 1) ? 24'hFFFFFF : 24'hFFFFFB, 1'b0);
        end
        @(negedge s_clk);
        f_clk = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge s_clk);
            #1;
            chk($sformatf("tog_hold%0d", n), p, 24'hFFFFFF, 1'b0);
        end
        f_clk = 1'b0;
        @(negedge s_clk);

        // ---- reset mid-run: driven-low pad is released immediately
        build(2);
        load_cfg();
        @(negedge s_clk);
        drv_en  = 24'h3;
        drv_val = 24'h0;
        #1;
        chk("run_pre_rst", p, 24'hFFFFF8, 1'b0);
        async_reset();
        chk("run_rst_pads", p, 24'hFFFFFC, 1'b0);
        chk("run_rst_sout", {23'd0, sout}, 24'h0, 1'b0);
        release_reset();
        drv_en = '0;

        // ---- reset clears the LB flops: set FF, reset, reload, FF reads 0
        build(3);
        load_cfg();
        pulse();
        chk("ff_set", p, 24'hFFFFFF, 1'b0);
        async_reset();
        release_reset();
        load_cfg();
        #1;
        chk("ff_cleared", p, 24'hFFFFFB, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
